// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default operand width,
// controller state encoding and the bit-counter width helper.
package serial_adder_pkg;

  localparam int SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The bit counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// 1-bit full adder built from two cascaded half-adder stages.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  // First half adder combines the operand bits.
  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;

  // Second half adder folds in the incoming carry.
  assign sum       = ha0_sum ^ c;
  assign ha1_carry = ha0_sum & c;

  assign carry     = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell is time-shared over
// WIDTH cycles, LSB first. Define SERIAL_ADD_SUB_EN to add a 'sub' port
// that turns the operation into a + ~b + 1 (cout=1 means no borrow).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  // Operand conditioning at acceptance: subtraction inverts b and forces
  // the initial carry to 1, discarding cin.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  serial_fa_cell u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    // NOTE: every target gets a hold default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      RUN: begin
        // start is deliberately ignored here so the in-flight result survives.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
          cout_d  = fa_carry;
        end
      end
      default: begin
        // IDLE and DONE both accept a new operation; DONE lasts one cycle.
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous clear of all control and datapath state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Define
// SERIAL_ADD_SUB_EN to also exercise the subtract path.
module tb_serial_adder_ctrl;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, sum} of the whole-word operation, modulo 2^WIDTH.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic c, input logic s);
    logic [WIDTH-1:0] yy;
    logic             ci;
    yy = s ? ~y : y;
    ci = s ? 1'b1 : c;
    return {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, ci};
  endfunction

  // Present operands and start at the current (negedge) time; one rising
  // edge accepts them, then the inputs are scrambled to prove they were latched.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, input logic sv, input string tag);
    a = av; b = bv; cin = cv;
`ifdef SERIAL_ADD_SUB_EN
    sub = sv;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub = ~sv;
`endif
    check({tag, "_busy_after_accept"}, 32'(busy), 32'(1));
  endtask

  task automatic wait_done(output int cyc, input string tag);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < TIMEOUT);
    check({tag, "_done_seen"}, 32'(done), 32'(1));
    check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
  endtask

  // Full operation from a negedge back to a negedge.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic cv, input logic sv);
    logic [WIDTH:0] exp;
    int cyc;
    exp = model(av, bv, cv, sv);
    launch(av, bv, cv, sv, tag);
    wait_done(cyc, tag);
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH + 1));
    check({tag, "_sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(exp[WIDTH]));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'(0));
    check({tag, "_sum_hold"}, 32'(sum), 32'(exp[WIDTH-1:0]));
  endtask

  initial begin
    logic [WIDTH:0] exp;
    logic [WIDTH:0] exp2;
    int cyc;
    int pulses;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rc;
    logic rs;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sum",  32'(sum),  32'(0));
    check("rst_cout", 32'(cout), 32'(0));

    // Release reset and request start at once: the first edge must accept.
    @(negedge clk);
    rst = 1'b0;
    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0);

    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0);

    // start pulsed again 3 cycles into RUN must be ignored.
    exp = model(8'h12, 8'h34, 1'b0, 1'b0);
    launch(8'h12, 8'h34, 1'b0, 1'b0, "restart");
    repeat (3) @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, "restart");
    check("restart_latency", 32'(cyc), 32'(WIDTH + 1 - 3));
    check("restart_sum", 32'(sum), 32'(exp[WIDTH-1:0]));
    check("restart_cout", 32'(cout), 32'(exp[WIDTH]));
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("restart_extra_done", 32'(pulses), 32'(0));
    check("restart_idle_busy", 32'(busy), 32'(0));

    // Reset 4 cycles into RUN clears everything immediately.
    launch(8'hAA, 8'h55, 1'b0, 1'b0, "midrst");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_sum",  32'(sum),  32'(0));
    check("midrst_cout", 32'(cout), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_03_04", 8'h03, 8'h04, 1'b0, 1'b0);

    // start held high through DONE: back-to-back, done pulses 9 cycles apart.
    exp  = model(8'h21, 8'h43, 1'b0, 1'b0);
    exp2 = model(8'h9C, 8'h7E, 1'b1, 1'b0);
    a = 8'h21; b = 8'h43; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h9C; b = 8'h7E; cin = 1'b1;
    wait_done(cyc, "b2b_first");
    check("b2b_first_latency", 32'(cyc), 32'(WIDTH + 1));
    check("b2b_first_sum", 32'(sum), 32'(exp[WIDTH-1:0]));
    check("b2b_first_cout", 32'(cout), 32'(exp[WIDTH]));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'(1));
    wait_done(cyc, "b2b_second");
    check("b2b_spacing", 32'(cyc), 32'(WIDTH + 1));
    check("b2b_second_sum", 32'(sum), 32'(exp2[WIDTH-1:0]));
    check("b2b_second_cout", 32'(cout), 32'(exp2[WIDTH]));
    @(negedge clk);
    check("b2b_done_one_cycle", 32'(done), 32'(0));

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1);
    run_op("sub_07_05", 8'h07, 8'h05, 1'b1, 1'b1);
`endif

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
